tile_seq_controller: RTL and testbench

TILE_SEQ_CONTROLLER -- requirements
Module: tile_seq_controller

---
 rtl/tile_seq_controller.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_tile_seq_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_seq_controller.sv
// Tile sequencing controller: walks each tile of a job through SRAM fetch, buffer
// update, dispatch, compute and writeback. It also manages a two-bank ping-pong
// buffer that feeds index vectors to the PE array.
// Optional build macro CTRL_TIMEOUT_EN adds a per-state watchdog that aborts a stalled
// job and raises a sticky error flag.
module tile_seq_controller #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BUF_AW      = 6,
  parameter int unsigned IDX_W       = 224,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_tiles,
  input  logic              fifo_empty,
  input  logic              dispatcher_done,
  input  logic              zcip_done,
  input  logic              pe_done,
  input  logic              index_en,
  input  logic [IDX_W-1:0]  index_vector_buffer,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_w_rd_addr,
  output logic [ADDR_W-1:0] sram_a_rd_addr,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic              buf_wr_en,
  output logic [BUF_AW-1:0] buf_w_wr_addr,
  output logic [BUF_AW-1:0] buf_a_wr_addr,
  output logic [BUF_AW-1:0] buf_w_rd_addr,
  output logic [BUF_AW-1:0] buf_a_rd_addr,
  output logic              disp_en,
  output logic              weight_sign_en,
  output logic              sram_wr_en,
  output logic [1:0]        acc_en,
  output logic [IDX_W-1:0]  index_vector,
  output logic              index_valid,
  output logic              idx_overflow,
  output logic [ADDR_W-1:0] tile_idx
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchSram,
    StUpdateBuffer,
    StFetchData,
    StDispatch,
    StCompute,
    StWriteback,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] num_tiles_q, num_tiles_d;
  logic [ADDR_W-1:0] tile_idx_q, tile_idx_d;
  logic [ADDR_W-1:0] tile_next;
  logic [ADDR_W-1:0] sram_w_rd_addr_q, sram_a_rd_addr_q;
  logic [BUF_AW-1:0] buf_w_rd_addr_q, buf_a_rd_addr_q;
  logic              sram_addr_inc;
  logic              buf_addr_inc;
  logic              job_start;

  // Index ping-pong storage
  logic [IDX_W-1:0] bank0_q, bank1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;
  logic             idx_overflow_q;
  logic             idx_push, idx_pop;

  assign tile_next = tile_idx_q + ADDR_W'(1);

`ifdef CTRL_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  logic        wd_watched;
  logic        timeout_hit;
  logic        timeout_abort;
  logic        error_q;

  assign wd_watched  = (state_q == StFetchSram) || (state_q == StFetchData) ||
                       (state_q == StDispatch)  || (state_q == StCompute);
  assign timeout_hit = wd_watched && (wd_cnt_q == TIMEOUT_CYC - 1);
`endif

  // Next-state logic and Moore outputs decoded from the current state
  always_comb begin
    state_d        = state_q;
    num_tiles_d    = num_tiles_q;
    tile_idx_d     = tile_idx_q;
    sram_addr_inc  = 1'b0;
    buf_addr_inc   = 1'b0;
    job_start      = 1'b0;
    busy           = (state_q != StIdle);
    done           = 1'b0;
    sram_en        = 1'b0;
    buf_wr_en      = 1'b0;
    buf_w_wr_addr  = '0;
    buf_a_wr_addr  = '0;
    disp_en        = 1'b0;
    weight_sign_en = 1'b0;
    sram_wr_en     = 1'b0;
    sram_wr_addr   = '0;
    acc_en         = 2'b00;
    index_vector   = '0;
    index_valid    = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    timeout_abort  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          job_start = 1'b1;
          if (num_tiles == '0) begin
            state_d = StDone;
          end else begin
            num_tiles_d = num_tiles;
            tile_idx_d  = '0;
            state_d     = fifo_empty ? StFetchSram : StFetchData;
          end
        end
      end
      StFetchSram: begin
        sram_en = 1'b1;
        if (!fifo_empty) begin
          sram_addr_inc = 1'b1;
          state_d       = StUpdateBuffer;
        end
      end
      StUpdateBuffer: begin
        buf_wr_en     = 1'b1;
        buf_w_wr_addr = sram_w_rd_addr_q[BUF_AW-1:0];
        buf_a_wr_addr = sram_a_rd_addr_q[BUF_AW-1:0];
        state_d       = StFetchData;
      end
      StFetchData: begin
        disp_en      = 1'b1;
        buf_addr_inc = 1'b1;
        if (dispatcher_done) begin
          state_d = StDispatch;
        end
      end
      StDispatch: begin
        weight_sign_en = 1'b1;
        if (zcip_done) begin
          state_d = StCompute;
        end
      end
      StCompute: begin
        acc_en = 2'b11;
        if (occ_q != 2'd0) begin
          index_valid  = 1'b1;
          index_vector = rd_ptr_q ? bank1_q : bank0_q;
        end
        if (pe_done) begin
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        sram_wr_en   = 1'b1;
        sram_wr_addr = sram_a_rd_addr_q;
        tile_idx_d   = tile_next;
        if (tile_next == num_tiles_q) begin
          state_d = StDone;
        end else begin
          state_d = fifo_empty ? StFetchSram : StFetchData;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef CTRL_TIMEOUT_EN
    // A stage that finishes on its last allowed cycle still proceeds normally
    if (timeout_hit && (state_d == state_q)) begin
      state_d       = StDone;
      timeout_abort = 1'b1;
    end
`endif
  end

  // State register and job bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      num_tiles_q <= '0;
      tile_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_tiles_q <= num_tiles_d;
      tile_idx_q  <= tile_idx_d;
    end
  end

  // SRAM and local-buffer address counters; free-running across jobs, wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_w_rd_addr_q <= '0;
      sram_a_rd_addr_q <= '0;
      buf_w_rd_addr_q  <= '0;
      buf_a_rd_addr_q  <= '0;
    end else begin
      if (sram_addr_inc) begin
        sram_w_rd_addr_q <= sram_w_rd_addr_q + ADDR_W'(1);
        sram_a_rd_addr_q <= sram_a_rd_addr_q + ADDR_W'(1);
      end
      if (buf_addr_inc) begin
        buf_w_rd_addr_q <= buf_w_rd_addr_q + BUF_AW'(1);
        buf_a_rd_addr_q <= buf_a_rd_addr_q + BUF_AW'(1);
      end
    end
  end

  // Pop only when a bank actually holds data so the pointers never desynchronise
  assign idx_pop  = (state_q == StCompute) && pe_done && (occ_q != 2'd0);
  assign idx_push = index_en && ((occ_q != 2'd2) || idx_pop);

  // Index ping-pong banks, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0_q        <= '0;
      bank1_q        <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
      idx_overflow_q <= 1'b0;
    end else begin
      if (idx_push) begin
        if (wr_ptr_q) begin
          bank1_q <= index_vector_buffer;
        end else begin
          bank0_q <= index_vector_buffer;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (idx_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({idx_push, idx_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (index_en && !idx_push) begin
        idx_overflow_q <= 1'b1;
      end
    end
  end

`ifdef CTRL_TIMEOUT_EN
  // Cycles spent in the current watched state; restarts on every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (wd_watched && (state_d == state_q)) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end else begin
      wd_cnt_q <= '0;
    end
  end

  // Error stays set after an abort until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (job_start) begin
      error_q <= 1'b0;
    end else if (timeout_abort) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_cfg;
  assign unused_cfg = job_start ^ (TIMEOUT_CYC == 32'd0);
  assign error      = 1'b0;
`endif

  assign sram_w_rd_addr = sram_w_rd_addr_q;
  assign sram_a_rd_addr = sram_a_rd_addr_q;
  assign buf_w_rd_addr  = buf_w_rd_addr_q;
  assign buf_a_rd_addr  = buf_a_rd_addr_q;
  assign tile_idx       = tile_idx_q;
  assign idx_overflow   = idx_overflow_q;

endmodule

// File: tb/tb_tile_seq_controller.sv
// Self-checking bench for tile_seq_controller: a directed vector table for a two-tile
// job, followed by hand-written sequences for FIFO stalls, index overflow, mid-job
// reset and the optional watchdog.
module tb_tile_seq_controller;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned BUF_AW      = 6;
  localparam int unsigned IDX_W       = 224;
  localparam int unsigned TIMEOUT_CYC = 16;

  // Flag layout: {busy, done, sram_en, buf_wr_en, disp_en, weight_sign_en, acc_en, sram_wr_en}
  localparam logic [8:0] F_IDLE = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] F_FS   = 9'b1_0_1_0_0_0_00_0;
  localparam logic [8:0] F_UB   = 9'b1_0_0_1_0_0_00_0;
  localparam logic [8:0] F_FD   = 9'b1_0_0_0_1_0_00_0;
  localparam logic [8:0] F_DIS  = 9'b1_0_0_0_0_1_00_0;
  localparam logic [8:0] F_CMP  = 9'b1_0_0_0_0_0_11_0;
  localparam logic [8:0] F_WB   = 9'b1_0_0_0_0_0_00_1;
  localparam logic [8:0] F_DONE = 9'b1_1_0_0_0_0_00_0;

  logic              clk, rst, start, fifo_empty;
  logic [ADDR_W-1:0] num_tiles;
  logic              dispatcher_done, zcip_done, pe_done, index_en;
  logic [IDX_W-1:0]  index_vector_buffer;
  logic              busy, done, error, sram_en, buf_wr_en;
  logic [ADDR_W-1:0] sram_w_rd_addr, sram_a_rd_addr, sram_wr_addr, tile_idx;
  logic [BUF_AW-1:0] buf_w_wr_addr, buf_a_wr_addr, buf_w_rd_addr, buf_a_rd_addr;
  logic              disp_en, weight_sign_en, sram_wr_en;
  logic [1:0]        acc_en;
  logic [IDX_W-1:0]  index_vector;
  logic              index_valid, idx_overflow;

  tile_seq_controller #(
    .ADDR_W      (ADDR_W),
    .BUF_AW      (BUF_AW),
    .IDX_W       (IDX_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .num_tiles           (num_tiles),
    .fifo_empty          (fifo_empty),
    .dispatcher_done     (dispatcher_done),
    .zcip_done           (zcip_done),
    .pe_done             (pe_done),
    .index_en            (index_en),
    .index_vector_buffer (index_vector_buffer),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .sram_en             (sram_en),
    .sram_w_rd_addr      (sram_w_rd_addr),
    .sram_a_rd_addr      (sram_a_rd_addr),
    .sram_wr_addr        (sram_wr_addr),
    .buf_wr_en           (buf_wr_en),
    .buf_w_wr_addr       (buf_w_wr_addr),
    .buf_a_wr_addr       (buf_a_wr_addr),
    .buf_w_rd_addr       (buf_w_rd_addr),
    .buf_a_rd_addr       (buf_a_rd_addr),
    .disp_en             (disp_en),
    .weight_sign_en      (weight_sign_en),
    .sram_wr_en          (sram_wr_en),
    .acc_en              (acc_en),
    .index_vector        (index_vector),
    .index_valid         (index_valid),
    .idx_overflow        (idx_overflow),
    .tile_idx            (tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every scalar/vector output except index_vector, packed for the all-zero checks
  logic [99:0] all_outs;
  assign all_outs = {busy, done, error, sram_en, sram_w_rd_addr, sram_a_rd_addr, sram_wr_addr,
                     buf_wr_en, buf_w_wr_addr, buf_a_wr_addr, buf_w_rd_addr, buf_a_rd_addr,
                     disp_en, weight_sign_en, sram_wr_en, acc_en, index_valid, idx_overflow,
                     tile_idx};

  logic [84:0] tbl_act;
  assign tbl_act = {busy, done, sram_en, buf_wr_en, disp_en, weight_sign_en, acc_en, sram_wr_en,
                    tile_idx, sram_w_rd_addr, sram_a_rd_addr, sram_wr_addr,
                    buf_w_rd_addr, buf_a_rd_addr};

  typedef struct {
    logic              st;
    logic [ADDR_W-1:0] nt;
    logic              fe, dd, zd, pd;
    logic [8:0]        fl;
    logic [ADDR_W-1:0] tile, sr, sw;
    logic [BUF_AW-1:0] br;
  } vec_t;

  vec_t vecs [17];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [ADDR_W-1:0] nt, input logic fe,
                              input logic dd, input logic zd, input logic pd,
                              input logic [8:0] fl, input logic [ADDR_W-1:0] tile,
                              input logic [ADDR_W-1:0] sr, input logic [ADDR_W-1:0] sw,
                              input logic [BUF_AW-1:0] br);
    vec_t v;
    v.st = st; v.nt = nt; v.fe = fe; v.dd = dd; v.zd = zd; v.pd = pd;
    v.fl = fl; v.tile = tile; v.sr = sr; v.sw = sw; v.br = br;
    return v;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; num_tiles = '0; fifo_empty = 0; dispatcher_done = 0; zcip_done = 0;
    pe_done = 0; index_en = 0; index_vector_buffer = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From FETCH_DATA: dispatcher_done, then zcip_done, landing in COMPUTE
  task automatic to_compute();
    dispatcher_done = 1; cyc(); dispatcher_done = 0;
    zcip_done = 1;       cyc(); zcip_done = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [IDX_W-1:0] v1, v2, v3, v4;
    int n_sram, n_bufwr, n;
    logic [BUF_AW-1:0] bw_addr, ba_addr;

    v1 = {7{32'h1111_0001}};
    v2 = {7{32'h2222_0002}};
    v3 = {7{32'h3333_0003}};
    v4 = {7{32'h4444_0004}};

    rst = 1'b1;
    clear_inputs();

    // Reset state
    cyc(); cyc();
    check("reset_outs", all_outs, '0);
    check("reset_idxvec", index_vector, '0);
    rst = 1'b0;

    // Two-tile job with stray pulses, then a zero-tile job
    //            st nt fe dd zd pd  flags   tile sr sw br
    vecs[0]  = mk(1, 2, 0, 0, 0, 0, F_FD,   0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, F_FD,   0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0, F_DIS,  0, 0, 0, 2);
    vecs[3]  = mk(1, 5, 0, 0, 0, 1, F_DIS,  0, 0, 0, 2);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, F_CMP,  0, 0, 0, 2);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, F_WB,   0, 0, 0, 2);
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, F_FS,   1, 0, 0, 2);
    vecs[7]  = mk(0, 0, 1, 1, 0, 0, F_FS,   1, 0, 0, 2);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, F_UB,   1, 1, 0, 2);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, F_FD,   1, 1, 0, 2);
    vecs[10] = mk(0, 0, 0, 1, 0, 0, F_DIS,  1, 1, 0, 3);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, F_CMP,  1, 1, 0, 3);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, F_WB,   1, 1, 1, 3);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, F_DONE, 2, 1, 0, 3);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, F_IDLE, 2, 1, 0, 3);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, F_DONE, 2, 1, 0, 3);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, F_IDLE, 2, 1, 0, 3);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = vecs[i].st; num_tiles = vecs[i].nt; fifo_empty = vecs[i].fe;
      dispatcher_done = vecs[i].dd; zcip_done = vecs[i].zd; pe_done = vecs[i].pd;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), tbl_act,
            {vecs[i].fl, vecs[i].tile, vecs[i].sr, vecs[i].sr, vecs[i].sw,
             vecs[i].br, vecs[i].br});
    end

    // FIFO empty for five cycles after start
    do_reset();
    start = 1; num_tiles = 1; fifo_empty = 1;
    cyc();
    start = 0;
    n_sram = 0; n_bufwr = 0; bw_addr = '1; ba_addr = '1;
    for (int i = 0; i < 12; i++) begin
      if (sram_en) n_sram++;
      if (buf_wr_en) begin
        n_bufwr++;
        bw_addr = buf_w_wr_addr;
        ba_addr = buf_a_wr_addr;
      end
      fifo_empty = (i < 5);
      cyc();
    end
    check("stall_sram_en_cycles", n_sram, 6);
    check("stall_buf_wr_cycles", n_bufwr, 1);
    check("stall_buf_w_wr_addr", bw_addr, 1);
    check("stall_buf_a_wr_addr", ba_addr, 1);
    check("stall_sram_w_rd_addr", sram_w_rd_addr, 1);
    check("stall_sram_a_rd_addr", sram_a_rd_addr, 1);

    // Index overflow and ping-pong ordering
    do_reset();
    index_en = 1; index_vector_buffer = v1; cyc();
    index_vector_buffer = v2; cyc();
    check("ovf_before_third", idx_overflow, 0);
    index_vector_buffer = v3; cyc();
    index_en = 0;
    check("ovf_after_third", idx_overflow, 1);
    start = 1; num_tiles = 3; cyc(); start = 0;
    to_compute();
    check("cmp1_valid", index_valid, 1);
    check("cmp1_vec", index_vector, v1);
    // Push together with pop while full must be accepted
    pe_done = 1; index_en = 1; index_vector_buffer = v4; cyc();
    pe_done = 0; index_en = 0;
    cyc();
    to_compute();
    check("cmp2_valid", index_valid, 1);
    check("cmp2_vec", index_vector, v2);
    pe_done = 1; cyc(); pe_done = 0;
    cyc();
    to_compute();
    check("cmp3_vec", index_vector, v4);
    pe_done = 1; cyc(); pe_done = 0;
    cyc();
    check("job3_done", {done, tile_idx}, {1'b1, 16'd3});
    cyc();
    check("job3_idle", {busy, done, idx_overflow}, 3'b001);

    // Empty-bank compute, then reset in the middle of COMPUTE
    start = 1; num_tiles = 1; cyc(); start = 0;
    to_compute();
    check("cmp_empty", {index_valid, index_vector}, '0);
    index_en = 1; index_vector_buffer = v1; cyc(); index_en = 0;
    check("cmp_refill_vec", index_vector, v1);
    rst = 1;
    #1;
    check("midrst_outs", all_outs, '0);
    check("midrst_idxvec", index_vector, '0);
    cyc();
    rst = 0;
    cyc();
    check("post_rst_idle", busy, 0);
    start = 1; num_tiles = 1; cyc(); start = 0;
    to_compute();
    check("post_rst_occ0", index_valid, 0);
    pe_done = 1; cyc(); pe_done = 0;
    cyc();
    check("post_rst_done", done, 1);
    cyc();

    // Stall in DISPATCH
    start = 1; num_tiles = 1; cyc(); start = 0;
    dispatcher_done = 1; cyc(); dispatcher_done = 0;
    n = 0;
    while (weight_sign_en && n < 40) begin
      n++;
      cyc();
    end
`ifdef CTRL_TIMEOUT_EN
    check("wd_dispatch_cycles", n, 16);
    check("wd_done_error", {done, error}, 2'b11);
    cyc();
    check("wd_idle_sticky", {busy, error}, 2'b01);
    start = 1; num_tiles = 0; cyc(); start = 0;
    check("wd_err_cleared", {done, error}, 2'b10);
    cyc();
`else
    check("nowd_still_dispatch", n, 40);
    check("nowd_error", error, 0);
    zcip_done = 1; cyc(); zcip_done = 0;
    pe_done = 1; cyc(); pe_done = 0;
    cyc();
    check("nowd_done", {done, error}, 2'b10);
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
